// File: rtl/rx_slot_allocator_if.sv
// ----------------------------------------------------------------------------
// rx_slot_allocator_if
// Descriptor hand-off bundle between the RX slot allocator and the RX
// descriptor injection port of the RISC-V system.
//
// Signals
//   m_desc_slot   [SLOT_WIDTH-1:0]  allocated slot number
//   m_desc_addr   [ADDR_WIDTH-1:0]  buffer address of that slot
//   m_desc_valid                    descriptor valid
//   m_desc_ready                    downstream accepts the descriptor
//
// Modports
//   master : allocator side (drives slot/addr/valid, samples ready)
//   slave  : consumer side  (samples slot/addr/valid, drives ready)
// ----------------------------------------------------------------------------
interface rx_slot_allocator_if #(
    parameter int SLOT_WIDTH = 4,
    parameter int ADDR_WIDTH = 7
);
    logic [SLOT_WIDTH-1:0] m_desc_slot;
    logic [ADDR_WIDTH-1:0] m_desc_addr;
    logic                  m_desc_valid;
    logic                  m_desc_ready;

    modport master (
        output m_desc_slot,
        output m_desc_addr,
        output m_desc_valid,
        input  m_desc_ready
    );

    modport slave (
        input  m_desc_slot,
        input  m_desc_addr,
        input  m_desc_valid,
        output m_desc_ready
    );
endinterface

// File: rtl/rx_slot_allocator.sv
// ----------------------------------------------------------------------------
// rx_slot_allocator
// Free-slot manager for the RX descriptor injection port. Keeps a table of
// per-slot buffer addresses, tracks which configured slots are free, hands
// out one {slot, addr} descriptor per valid/ready handshake (round-robin
// selection) and takes slots back when a core releases them.
//
// Ports
//   clk                 in   logic clock
//   rst_n               in   asynchronous active-low reset
//   slot_addr_wr_no     in   slot being configured
//   slot_addr_wr_data   in   buffer address for that slot
//   slot_addr_wr_valid  in   configuration write strobe
//   slot_release_no     in   slot returned by a core
//   slot_release_valid  in   release strobe
//   m_desc              if   descriptor stream (master modport)
//   free_count          out  number of free slots (held descriptor excluded)
//   double_release_err  out  sticky flag: a release hit a slot not allocated
//   alloc_count         out  accepted descriptors (statistics build only)
//   release_count       out  valid releases       (statistics build only)
//
// Build option
//   RX_SLOT_ALLOC_STATS_EN : when defined, alloc_count / release_count are
//   live 32-bit wrapping counters; otherwise both are tied to zero.
// ----------------------------------------------------------------------------
module rx_slot_allocator #(
    parameter int SLOT_COUNT = 16,
    parameter int SLOT_WIDTH = $clog2(SLOT_COUNT),
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [SLOT_WIDTH-1:0] slot_addr_wr_no,
    input  logic [ADDR_WIDTH-1:0] slot_addr_wr_data,
    input  logic                  slot_addr_wr_valid,

    input  logic [SLOT_WIDTH-1:0] slot_release_no,
    input  logic                  slot_release_valid,

    rx_slot_allocator_if.master   m_desc,

    output logic [SLOT_WIDTH:0]   free_count,
    output logic                  double_release_err,
    output logic [31:0]           alloc_count,
    output logic [31:0]           release_count
);

    // ------------------------------------------------------------------------
    // Output register state
    // ------------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // ------------------------------------------------------------------------
    // Slot bookkeeping
    // ------------------------------------------------------------------------
    logic [SLOT_COUNT-1:0] r_free;
    logic [SLOT_COUNT-1:0] r_cfg;
    logic [ADDR_WIDTH-1:0] r_addr [SLOT_COUNT];
    logic [SLOT_WIDTH-1:0] r_rr;

    logic [SLOT_WIDTH-1:0] r_slot;
    logic [ADDR_WIDTH-1:0] r_daddr;
    logic [SLOT_WIDTH:0]   r_free_count;
    logic                  r_err;

    logic                  w_pick_found;
    logic [SLOT_WIDTH-1:0] w_pick_slot;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_held;
    logic                  w_rel_ok;
    logic                  w_rel_err;
    logic                  w_cfg_new;
    logic [SLOT_COUNT-1:0] w_free_nxt;

    // Number of set bits in the free vector; SLOT_WIDTH+1 bits so that a
    // fully free table reads SLOT_COUNT rather than wrapping to zero.
    function automatic logic [SLOT_WIDTH:0] popcount(input logic [SLOT_COUNT-1:0] v);
        logic [SLOT_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            cnt = cnt + {{SLOT_WIDTH{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------------
    // Round-robin pick: first free slot at or after r_rr, wrapping. Scanning
    // from the farthest offset down lets the nearest hit win without a break.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [SLOT_WIDTH-1:0] idx;
        w_pick_found = 1'b0;
        w_pick_slot  = '0;
        idx          = '0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            idx = r_rr + SLOT_WIDTH'(i);
            if (r_free[idx]) begin
                w_pick_found = 1'b1;
                w_pick_slot  = idx;
            end
        end
    end

    assign w_held   = (r_state == ST_FULL);
    assign w_accept = w_held && m_desc.m_desc_ready;

    // ------------------------------------------------------------------------
    // Output register FSM: next state and load decision
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_pick_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    if (w_pick_found) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // A release is only honoured for a configured slot that is out with a
    // core: not free and not the one sitting in the output register.
    assign w_rel_ok  = slot_release_valid
                     && r_cfg[slot_release_no]
                     && !r_free[slot_release_no]
                     && !(w_held && (r_slot == slot_release_no));
    assign w_rel_err = slot_release_valid && !w_rel_ok;

    assign w_cfg_new = slot_addr_wr_valid && !r_cfg[slot_addr_wr_no];

    // Next free vector. The picked slot is free and a releasable slot is
    // busy, so the clear and the sets never target the same bit.
    always_comb begin
        w_free_nxt = r_free;
        if (w_load) begin
            w_free_nxt[w_pick_slot] = 1'b0;
        end
        if (w_rel_ok) begin
            w_free_nxt[slot_release_no] = 1'b1;
        end
        if (w_cfg_new) begin
            w_free_nxt[slot_addr_wr_no] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State, slot vectors, output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_free       <= '0;
            r_cfg        <= '0;
            r_rr         <= '0;
            r_slot       <= '0;
            r_daddr      <= '0;
            r_free_count <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_free       <= w_free_nxt;
            // Registered alongside r_free so the count always matches it.
            r_free_count <= popcount(w_free_nxt);
            if (w_cfg_new) begin
                r_cfg[slot_addr_wr_no] <= 1'b1;
            end
            if (w_load) begin
                r_slot  <= w_pick_slot;
                r_daddr <= r_addr[w_pick_slot];
                r_rr    <= w_pick_slot + SLOT_WIDTH'(1);
            end
            if (w_rel_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Address table: writes always update the address, configured or not
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_COUNT; i++) begin
                r_addr[i] <= '0;
            end
        end else if (slot_addr_wr_valid) begin
            r_addr[slot_addr_wr_no] <= slot_addr_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
`ifdef RX_SLOT_ALLOC_STATS_EN
    logic [31:0] r_alloc_cnt;
    logic [31:0] r_rel_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alloc_cnt <= '0;
            r_rel_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_alloc_cnt <= r_alloc_cnt + 32'd1;
            end
            if (w_rel_ok) begin
                r_rel_cnt <= r_rel_cnt + 32'd1;
            end
        end
    end

    assign alloc_count   = r_alloc_cnt;
    assign release_count = r_rel_cnt;
`else
    assign alloc_count   = '0;
    assign release_count = '0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_desc.m_desc_valid = w_held;
    assign m_desc.m_desc_slot  = r_slot;
    assign m_desc.m_desc_addr  = r_daddr;
    assign free_count          = r_free_count;
    assign double_release_err  = r_err;

endmodule
